// File: rtl/reg_dump_pkg.sv
// Shared types and helpers for the register dump reader.
// Build option: define REG_DUMP_CHECKSUM_EN to append an XOR checksum word.
package reg_dump_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int DATA_W_DEF   = 16;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index of the word that carries Out_last.
  function automatic int final_idx(input int num_regs, input bit cksum_en);
    return cksum_en ? num_regs : num_regs - 1;
  endfunction

endpackage

// File: rtl/reg_dump_snapshot.sv
// Capture buffer for the register file with an indexed read port.
// With REG_DUMP_CHECKSUM_EN, index NUM_REGS reads the XOR of the captured words.
module reg_dump_snapshot
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [NUM_REGS*DATA_W-1:0] reg_bus,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] snap_q [NUM_REGS];
  logic [DATA_W-1:0] snap_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      snap_d[i] = snap_q[i];
      if (load) snap_d[i] = reg_bus[DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) snap_q[i] <= '0;
      else       snap_q[i] <= snap_d[i];
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_q;
  logic [DATA_W-1:0] cksum_d;

  // Checksum is taken from the bus at capture time so it matches the snapshot.
  always_comb begin
    cksum_d = cksum_q;
    if (load) begin
      cksum_d = '0;
      for (int i = 0; i < NUM_REGS; i++) cksum_d = cksum_d ^ reg_bus[DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = snap_q[i];
    end
    if (rd_idx == IDX_W'(NUM_REGS)) rd_data = cksum_q;
  end
`else
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = snap_q[i];
    end
  end
`endif

endmodule

// File: rtl/reg_dump_reader.sv
// Snapshots R0..R7 on Start and streams them over a valid/ready port.
// Build option: REG_DUMP_CHECKSUM_EN appends an XOR checksum word at idx NUM_REGS.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [NUM_REGS*DATA_W-1:0] Reg_bus,
  output logic [DATA_W-1:0]          Out_data,
  output logic [IDX_W-1:0]           Out_idx,
  output logic                       Out_valid,
  input  logic                       Out_ready,
  output logic                       Out_last,
  output logic                       Busy,
  output logic                       Done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(final_idx(NUM_REGS, CHECKSUM_EN));

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              load;
  logic [DATA_W-1:0] rd_data;

  reg_dump_snapshot #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_snapshot (
    .clk     (Clk),
    .reset   (Reset),
    .load    (load),
    .reg_bus (Reg_bus),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (Out_ready) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode registered state only, so they hold steady while stalled.
  always_comb begin
    Out_valid = (state_q == SEND);
    Out_data  = Out_valid ? rd_data : '0;
    Out_idx   = Out_valid ? idx_q : '0;
    Out_last  = Out_valid && (idx_q == LAST_IDX);
    Busy      = Out_valid;
    Done      = (state_q == DONE);
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side companion to the eight 16-bit general-purpose registers (R0..R7) of the simple computer.
- On a Start request it snapshots all eight register values in one cycle, then streams them out one word per handshake over a valid/ready interface, in order R0 to R7.
- Consumers are the debug/hex-display path and any serial dump logic.

Parameters:
- NUM_REGS, 8, number of registers captured and streamed.
- DATA_W, 16, width of each register word.
- IDX_W, 4, width of the word index output. Must hold NUM_REGS (checksum slot included).

Ports:
- Clk  in  1  system clock, all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  dump request. Sampled only in IDLE.
- Reg_bus  in  NUM_REGS*DATA_W  packed register values; Ri occupies bits [DATA_W*i+DATA_W-1 : DATA_W*i].
- Out_data  out  DATA_W  current word.
- Out_idx  out  IDX_W  index of current word (0..NUM_REGS-1, or NUM_REGS for checksum).
- Out_valid  out  1  Out_data/Out_idx/Out_last are valid.
- Out_ready  in  1  consumer accepts word when Out_valid && Out_ready at posedge.
- Out_last  out  1  high with the final word of the dump.
- Busy  out  1  high from the cycle after Start acceptance until the final word is accepted.
- Done  out  1  one-cycle pulse in the cycle after the final word is accepted.

Behaviour:
- Reset is synchronous, active-high; clock is Clk.
- Reset values: Out_data=0, Out_idx=0, Out_valid=0, Out_last=0, Busy=0, Done=0, state=IDLE, snapshot buffer all 0.
- Reset takes priority over every other input in the same cycle.
- Reset asserted mid-dump aborts the dump. No Done pulse is generated.

State machine (IDLE, SEND, DONE):
- IDLE:
  - Start=1 at posedge: capture all NUM_REGS words of Reg_bus into the snapshot buffer, set idx=0, go to SEND.
  - Start=0: remain in IDLE.
- SEND:
  - Out_valid=1, Out_data=snapshot[idx], Out_idx=idx, Busy=1.
  - On handshake with a non-final word: idx increments and the next word is presented in the following cycle. This gives 1 word/cycle when Out_ready is held high.
  - On handshake with the final word: go to DONE.
- DONE:
  - Out_valid=0, Busy=0, Done=1 for exactly one cycle, then go to IDLE.

Latency and data rules:
- Start accepted at edge N gives the first Out_valid at edge N+1.
- With Out_ready held high, NUM_REGS words take NUM_REGS cycles, and Done pulses one cycle after the last handshake.
- Handshake stability: while Out_valid=1 and Out_ready=0, Out_data, Out_idx and Out_last hold stable. Out_valid never drops without a handshake, except on Reset.
- Start while in SEND or DONE is ignored (not queued).
- Reg_bus changes after capture do not affect the streamed data.
- Out_last=1 only in the cycle(s) when the final word is presented.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - After R(NUM_REGS-1), one extra word is sent with Out_idx=NUM_REGS.
  - Its value is the XOR of all NUM_REGS snapshot words, computed at capture and registered.
  - Out_last moves to the checksum word.
  - Total words = NUM_REGS+1.
- Undefined:
  - No checksum word or logic.
  - Out_last is on idx NUM_REGS-1.

Decomposition:
- Package reg_dump_pkg:
  - state enum (IDLE, SEND, DONE);
  - localparams NUM_REGS_DEF=8, DATA_W_DEF=16;
  - function computing the final index (with and without checksum).
- One sub-module is natural: reg_dump_snapshot, the NUM_REGS x DATA_W capture buffer with a load enable and indexed read mux, plus checksum XOR when enabled.
- The FSM and handshake logic stay in the top module.

Test Plan:
1. Reg_bus = R0..R7 = 16'h0001..16'h0008, Start pulse, Out_ready=1 constant -> words 0001..0008 on 8 consecutive cycles, idx 0..7, Out_last on idx 7, Done pulse one cycle after idx 7 handshake, Busy low again.
2. Same data, Out_ready toggled 1,0,0,1,... -> each word held stable while Out_ready=0; the sequence is still 0001..0008 with no skips or duplicates.
3. Start, then change Reg_bus to all 16'hFFFF on the next cycle -> the stream still outputs the captured 0001..0008.
4. Start, Reset asserted on the 3rd word -> next cycle all outputs 0 and state IDLE, no Done pulse; a new Start then dumps from idx 0.
5. Start re-pulsed during SEND and in the Done cycle -> ignored; exactly one dump of 8 words, one Done pulse.
6. With REG_DUMP_CHECKSUM_EN, R0..R7 = 16'hA5A5, 16'h5A5A, 16'h0000 x6 -> a 9th word 16'hFFFF with idx 8 and Out_last, and Out_last absent on idx 7.
